pll_supervisor: RTL



---
 rtl/pll_supervisor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_supervisor
// Brief    : Sequences PLL RESET, qualifies LOCK, and holds SDRAM logic in reset
//            until lock is stable. Retries on timeout, re-sequences on lock loss.
//            Optional macro PLL_SUP_GLITCH_FILTER_EN ignores short lock dropouts in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module pll_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int c_MAX_A   = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int c_MAX_CYC = (c_MAX_A > LOCK_TIMEOUT_CYC) ? c_MAX_A : LOCK_TIMEOUT_CYC;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK sample that enters STABLE is the first of the stable run
    localparam logic [c_CNT_W-1:0] c_STB_LAST =
        c_CNT_W'((LOCK_STABLE_CYC >= 2) ? (LOCK_STABLE_CYC - 2) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_RETRY = 4'(MAX_RETRIES);

    localparam logic [2:0] c_ST_PRST   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_STABLE = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_FAIL   = 3'd4;

    logic               r_lock_meta;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_nxt;
    logic [7:0]         r_loss_cnt;
    logic               w_loss_evt;
    logic               w_lock_lost;
    logic               r_pll_reset;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_fail;
    logic               w_pll_reset_nxt;
    logic               w_ready_nxt;
    logic               w_fail_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

`ifdef PLL_SUP_GLITCH_FILTER_EN
    logic [1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_RUN) || r_lock_s) begin
            r_drop_cnt <= 2'd0;
        end else if (r_drop_cnt != 2'd3) begin
            r_drop_cnt <= r_drop_cnt + 2'd1;
        end
    end

    // Fourth consecutive low sample declares the loss
    assign w_lock_lost = !r_lock_s && (r_drop_cnt == 2'd3);
`else
    assign w_lock_lost = !r_lock_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_PRST;
            r_cnt      <= '0;
            r_retry    <= 4'd0;
            r_loss_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_loss_evt  = 1'b0;
        case (r_state)
            c_ST_PRST: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_lock_s) begin
                    w_state_nxt = (LOCK_STABLE_CYC == 1) ? c_ST_RUN : c_ST_STABLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    if (r_retry == c_MAX_RETRY) begin
                        w_state_nxt = c_ST_FAIL;
                    end else begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = c_ST_PRST;
                    end
                end
            end
            c_ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_lock_lost) begin
                    w_state_nxt = c_ST_PRST;
                    w_loss_evt  = 1'b1;
                end
            end
            c_ST_FAIL: begin
                w_state_nxt = c_ST_FAIL;
            end
            default: begin
                w_state_nxt = c_ST_PRST;
            end
        endcase

        if (w_state_nxt == c_ST_RUN) begin
            w_retry_nxt = 4'd0;
        end

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_CNT_MAX) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    always_comb begin
        w_pll_reset_nxt = (w_state_nxt == c_ST_PRST) || (w_state_nxt == c_ST_FAIL);
        w_ready_nxt     = (w_state_nxt == c_ST_RUN);
        w_fail_nxt      = (w_state_nxt == c_ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_pll_reset <= w_pll_reset_nxt;
            r_sys_rst   <= !w_ready_nxt;
            r_ready     <= w_ready_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign pll_reset_o     = r_pll_reset;
    assign sys_rst_o       = r_sys_rst;
    assign ready_o         = r_ready;
    assign fail_o          = r_fail;
    assign retry_cnt_o     = r_retry;
    assign lock_loss_cnt_o = r_loss_cnt;

endmodule
`default_nettype wire
